axi_rd_burst_ctrl: RTL and testbench

AXI4 read-burst controller that converts one linear read command (start address, beat count) into a sequence of aligned INCR bursts on an AXI4 master read channel. It splits at MAX_BURST_LEN beats and at 4 KB boundaries, and bounds the number of outstanding bursts. Returned read data is forwarded to an AXI-stream-style output with a command-level last flag, followed by a one-cycle completion status. It sits between DMA/test sequencers and the AXI4 interconnect.

---
 rtl/axi_rd_burst_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_axi_rd_burst_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_burst_ctrl.sv
// axi_rd_burst_ctrl
// Splits one linear read command (start address, beat count) into aligned AXI4 INCR
// bursts. A burst never exceeds MAX_BURST_LEN beats and never crosses a 4 KB page. At
// most MAX_OUTSTANDING bursts are in flight at once. Read data passes combinationally
// to a stream output whose last flag marks the final beat of the command. A one-cycle
// status pulse then reports whether any beat returned a non-OKAY response.
//
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_cmd_*/o_cmd_ready      command: start byte address, beat count, handshake
//   o_m_axi_ar*/i_..arready  AXI4 read address channel
//   i_m_axi_r*/o_m_axi_rready AXI4 read data channel
//   o_out_t*/i_out_tready    read data stream output
//   o_status_valid/_error    completion pulse and sticky response error
//   o_busy                   high from command accept through the status cycle
module axi_rd_burst_ctrl #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH       = 20,
  parameter int unsigned MAX_BURST_LEN   = 256,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  output logic [ADDR_WIDTH-1:0] o_m_axi_araddr,
  output logic [7:0]            o_m_axi_arlen,
  output logic [2:0]            o_m_axi_arsize,
  output logic [1:0]            o_m_axi_arburst,
  output logic                  o_m_axi_arlock,
  output logic [3:0]            o_m_axi_arcache,
  output logic [2:0]            o_m_axi_arprot,
  output logic [3:0]            o_m_axi_arqos,
  output logic [3:0]            o_m_axi_arregion,
  output logic                  o_m_axi_arvalid,
  input  logic                  i_m_axi_arready,
  input  logic [DATA_WIDTH-1:0] i_m_axi_rdata,
  input  logic [1:0]            i_m_axi_rresp,
  input  logic                  i_m_axi_rlast,
  input  logic                  i_m_axi_rvalid,
  output logic                  o_m_axi_rready,
  output logic [DATA_WIDTH-1:0] o_out_tdata,
  output logic                  o_out_tvalid,
  output logic                  o_out_tlast,
  input  logic                  i_out_tready,
  output logic                  o_status_valid,
  output logic                  o_status_error,
  output logic                  o_busy
);

  localparam int unsigned ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int unsigned OUT_W    = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                r_state;
  state_e                w_state_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_rx_cnt;
  logic [OUT_W-1:0]      r_outstanding;
  logic                  r_err;
  logic                  r_arvalid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [31:0]           r_beats;

  logic                  w_cmd_hs;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_rlast_hs;
  logic                  w_r_active;
  logic [11:0]           w_page_off;
  logic [LEN_WIDTH-1:0]  w_calc_rem;
  logic [12:0]           w_page_beats;
  logic [31:0]           w_cap;
  logic [31:0]           w_beats;
  logic [OUT_W-1:0]      w_outstanding_next;
  logic [LEN_WIDTH-1:0]  w_rx_next;

  assign w_cmd_hs   = i_cmd_valid & o_cmd_ready;
  assign w_ar_hs    = r_arvalid & i_m_axi_arready;
  assign w_r_hs     = w_r_active & i_m_axi_rvalid & i_out_tready;
  assign w_rlast_hs = w_r_hs & i_m_axi_rlast;

  // Burst length. In IDLE it is computed from the incoming command so the first AR
  // can be presented in the cycle right after the command handshake.
  always_comb begin
    w_page_off   = (r_state == StIdle) ? i_cmd_addr[11:0] : r_addr[11:0];
    w_calc_rem   = (r_state == StIdle) ? i_cmd_len : r_remaining;
    w_page_beats = (13'h1000 - {1'b0, w_page_off}) >> ADDR_LSB;
    w_cap        = (32'(w_page_beats) < MAX_BURST_LEN) ? 32'(w_page_beats) : MAX_BURST_LEN;
    w_beats      = (32'(w_calc_rem) < w_cap) ? 32'(w_calc_rem) : w_cap;
  end

  // Same-cycle AR issue and burst completion cancel out.
  always_comb begin
    w_outstanding_next = r_outstanding;
    if (w_ar_hs && !w_rlast_hs) begin
      w_outstanding_next = r_outstanding + OUT_W'(1);
    end else if (!w_ar_hs && w_rlast_hs) begin
      w_outstanding_next = r_outstanding - OUT_W'(1);
    end
    w_rx_next = r_rx_cnt + (w_r_hs ? LEN_WIDTH'(1) : '0);
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state. WAIT looks at next-cycle counts so status follows the last beat
  // by exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_cmd_hs) w_state_next = StIssue;
      StIssue: if (w_ar_hs && (r_remaining == LEN_WIDTH'(r_beats))) w_state_next = StWait;
      StWait:  if ((w_outstanding_next == '0) && (w_rx_next == r_len)) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_cmd_ready    = (r_state == StIdle) & ~i_rst;
    w_r_active     = (r_state == StIssue) | (r_state == StWait);
    o_status_valid = (r_state == StDone);
    o_status_error = (r_state == StDone) & r_err;
    o_busy         = (r_state != StIdle);
  end

  // Datapath: AR channel registers, address/remaining bookkeeping, beat counter, error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr        <= '0;
      r_remaining   <= '0;
      r_len         <= '0;
      r_rx_cnt      <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
      r_arvalid     <= 1'b0;
      r_araddr      <= '0;
      r_arlen       <= '0;
      r_beats       <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      r_rx_cnt      <= w_rx_next;
      if (w_r_hs) begin
        r_err <= r_err | (i_m_axi_rresp != 2'b00);
      end
      if (w_cmd_hs) begin
        r_addr      <= i_cmd_addr;
        r_remaining <= i_cmd_len;
        r_len       <= i_cmd_len;
        r_rx_cnt    <= '0;
        r_err       <= 1'b0;
        r_arvalid   <= 1'b1;
        r_araddr    <= i_cmd_addr;
        r_arlen     <= 8'(w_beats - 32'd1);
        r_beats     <= w_beats;
      end else if (r_state == StIssue) begin
        if (w_ar_hs) begin
          // Drop arvalid for one cycle so the next length sees the updated address.
          r_arvalid   <= 1'b0;
          r_addr      <= r_addr + ADDR_WIDTH'(r_beats << ADDR_LSB);
          r_remaining <= r_remaining - LEN_WIDTH'(r_beats);
        end else if (!r_arvalid && (r_remaining != '0) &&
                     (r_outstanding < OUT_W'(MAX_OUTSTANDING))) begin
          r_arvalid <= 1'b1;
          r_araddr  <= r_addr;
          r_arlen   <= 8'(w_beats - 32'd1);
          r_beats   <= w_beats;
        end
      end
    end
  end

  assign o_m_axi_arvalid  = r_arvalid;
  assign o_m_axi_araddr   = r_araddr;
  assign o_m_axi_arlen    = r_arlen;
  assign o_m_axi_arsize   = 3'(ADDR_LSB);
  assign o_m_axi_arburst  = 2'b01;
  assign o_m_axi_arlock   = 1'b0;
  assign o_m_axi_arcache  = 4'b0011;
  assign o_m_axi_arprot   = 3'b000;
  assign o_m_axi_arqos    = 4'b0000;
  assign o_m_axi_arregion = 4'b0000;

  // R path is a pure pass-through while a command is active.
  assign o_m_axi_rready = w_r_active & i_out_tready;
  assign o_out_tdata    = i_m_axi_rdata;
  assign o_out_tvalid   = w_r_active & i_m_axi_rvalid;
  assign o_out_tlast    = w_r_active & i_m_axi_rvalid & (r_rx_cnt == r_len - LEN_WIDTH'(1));

endmodule

// File: tb/tb_axi_rd_burst_ctrl.sv
module tb_axi_rd_burst_ctrl;

  localparam int MAXO = 2;
  localparam logic [31:0] NOERR = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_addr;
  logic [19:0] cmd_len;
  logic        cmd_valid, cmd_ready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic        arlock, arvalid, arready;
  logic [3:0]  arcache, arqos, arregion;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [31:0] tdata;
  logic        tvalid, tlast, tready;
  logic        status_valid, status_error, busy;

  // bench-side controls
  logic        r_en;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_rd_burst_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .o_m_axi_araddr(araddr), .o_m_axi_arlen(arlen), .o_m_axi_arsize(arsize),
    .o_m_axi_arburst(arburst), .o_m_axi_arlock(arlock), .o_m_axi_arcache(arcache),
    .o_m_axi_arprot(arprot), .o_m_axi_arqos(arqos), .o_m_axi_arregion(arregion),
    .o_m_axi_arvalid(arvalid), .i_m_axi_arready(arready),
    .i_m_axi_rdata(rdata), .i_m_axi_rresp(rresp), .i_m_axi_rlast(rlast),
    .i_m_axi_rvalid(rvalid), .o_m_axi_rready(rready),
    .o_out_tdata(tdata), .o_out_tvalid(tvalid), .o_out_tlast(tlast),
    .i_out_tready(tready),
    .o_status_valid(status_valid), .o_status_error(status_error), .o_busy(busy)
  );

  function automatic logic [31:0] bdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  typedef struct packed {logic [31:0] addr; logic [7:0] len;} burst_t;
  typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [10:0] attr;} ar_rec_t;
  typedef struct packed {logic [31:0] data; logic last;} beat_t;

  // ---------------- slave model ----------------
  burst_t sq[$];
  int     bib = 0;

  initial begin : slave
    logic s_ar, s_r;
    burst_t nb;
    logic [31:0] ba;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    forever begin
      @(negedge clk);
      s_ar = arvalid & arready;
      s_r  = rvalid & rready;
      nb.addr = araddr;
      nb.len  = arlen;
      @(posedge clk);
      #2;
      if (rst) begin
        sq.delete();
        bib = 0;
      end else begin
        if (s_ar) sq.push_back(nb);
        if (s_r && sq.size() > 0) begin
          if (bib == int'(sq[0].len)) begin
            void'(sq.pop_front());
            bib = 0;
          end else begin
            bib++;
          end
        end
      end
      if (!rst && r_en && sq.size() > 0) begin
        ba     = sq[0].addr + 32'(bib * 4);
        rvalid = 1'b1;
        rdata  = bdata(ba);
        rlast  = (bib == int'(sq[0].len));
        rresp  = (ba == err_addr) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
      end
    end
  end

  // ---------------- monitor ----------------
  ar_rec_t ar_log[$];
  int      ar_cyc[$];
  beat_t   beat_log[$];
  int      rlast_cyc[$];
  int      last_beat_cyc = 0;
  int      out_model = 0;
  int      max_out = 0;
  int      ar_stab_viol = 0;
  int      bubble_viol = 0;
  int      out_viol = 0;
  int      rready_viol = 0;

  initial begin : monitor
    ar_rec_t rec;
    beat_t bt;
    logic pend, prev_hs, exp_rready;
    logic [31:0] p_addr;
    logic [7:0] p_len;
    pend = 1'b0; prev_hs = 1'b0; p_addr = '0; p_len = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        out_model = 0; pend = 1'b0; prev_hs = 1'b0;
      end else begin
        if (pend && (!arvalid || araddr != p_addr || arlen != p_len)) ar_stab_viol++;
        if (prev_hs && arvalid) bubble_viol++;
        if (arvalid && out_model >= MAXO) out_viol++;
        exp_rready = (busy && !status_valid) ? tready : 1'b0;
        if (rready !== exp_rready) rready_viol++;
        if (arvalid && arready) begin
          rec.addr = araddr;
          rec.len  = arlen;
          rec.attr = {arsize, arburst, arcache, arlock, |{arprot, arqos, arregion}};
          ar_log.push_back(rec);
          ar_cyc.push_back(cyc);
          out_model++;
        end
        if (tvalid && tready) begin
          bt.data = tdata;
          bt.last = tlast;
          beat_log.push_back(bt);
          if (tlast) last_beat_cyc = cyc;
        end
        if (rvalid && rready && rlast) begin
          out_model--;
          rlast_cyc.push_back(cyc);
        end
        if (out_model > max_out) max_out = out_model;
        pend    = arvalid && !arready;
        prev_hs = arvalid && arready;
        p_addr  = araddr;
        p_len   = arlen;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input int n);
    int k;
    @(posedge clk);
    #1;
    tready    = 1'b1;
    cmd_addr  = a;
    cmd_len   = 20'(n);
    cmd_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("cmd_accept", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_status(input bit toggle, output bit seen, output bit serr,
                             output int scyc);
    seen = 1'b0; serr = 1'b0; scyc = 0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (toggle) tready = ~tready;
      @(negedge clk);
      if (status_valid) begin
        seen = 1'b1;
        serr = status_error;
        scyc = cyc;
      end
    end
    check("status_seen", {63'd0, seen}, 64'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          len;
    logic [31:0] err_addr;
    bit          toggle;
    int          nb;
    logic [31:0] exp_addr [3];
    logic [7:0]  exp_len [3];
    bit          exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int base_ar, base_bt, got;
    bit seen, serr;
    int scyc;
    base_ar  = ar_log.size();
    base_bt  = beat_log.size();
    err_addr = v.err_addr;
    send_cmd(v.addr, v.len);
    @(negedge clk);
    check($sformatf("v%0d_arvalid_1cyc", idx), {63'd0, arvalid}, 64'd1);
    check($sformatf("v%0d_busy", idx), {63'd0, busy}, 64'd1);
    wait_status(v.toggle, seen, serr, scyc);
    if (seen) begin
      check($sformatf("v%0d_status_error", idx), {63'd0, serr}, {63'd0, v.exp_err});
      check($sformatf("v%0d_status_lat", idx), 64'(scyc), 64'(last_beat_cyc + 1));
      @(negedge clk);
      check($sformatf("v%0d_status_1cyc", idx), {63'd0, status_valid}, 64'd0);
      check($sformatf("v%0d_ready_after", idx), {63'd0, cmd_ready}, 64'd1);
    end
    got = ar_log.size() - base_ar;
    check($sformatf("v%0d_nbursts", idx), 64'(got), 64'(v.nb));
    for (int b = 0; b < v.nb && b < got; b++) begin
      check($sformatf("v%0d_b%0d_addr", idx, b), 64'(ar_log[base_ar+b].addr),
            64'(v.exp_addr[b]));
      check($sformatf("v%0d_b%0d_len", idx, b), 64'(ar_log[base_ar+b].len),
            64'(v.exp_len[b]));
      check($sformatf("v%0d_b%0d_attr", idx, b), 64'(ar_log[base_ar+b].attr),
            64'({3'd2, 2'b01, 4'b0011, 1'b0, 1'b0}));
    end
    got = beat_log.size() - base_bt;
    check($sformatf("v%0d_nbeats", idx), 64'(got), 64'(v.len));
    for (int k = 0; k < v.len && k < got; k++) begin
      check($sformatf("v%0d_beat%0d_data", idx, k), 64'(beat_log[base_bt+k].data),
            64'(bdata(v.addr + 32'(k * 4))));
      check($sformatf("v%0d_beat%0d_last", idx, k), {63'd0, beat_log[base_bt+k].last},
            {63'd0, k == v.len - 1});
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    vec_t vecs [7];
    int base_ar, base_bt, base_rl, k;
    bit seen, serr;
    int scyc;

    vecs[0] = '{32'h1000, 4, NOERR, 1'b0, 1, '{32'h1000, 32'h0, 32'h0},
                '{8'd3, 8'd0, 8'd0}, 1'b0};
    vecs[1] = '{32'h0FF8, 4, NOERR, 1'b0, 2, '{32'h0FF8, 32'h1000, 32'h0},
                '{8'd1, 8'd1, 8'd0}, 1'b0};
    vecs[2] = '{32'h0, 600, NOERR, 1'b0, 3, '{32'h0, 32'h400, 32'h800},
                '{8'd255, 8'd255, 8'd87}, 1'b0};
    vecs[3] = '{32'h2000, 4, 32'h2004, 1'b0, 1, '{32'h2000, 32'h0, 32'h0},
                '{8'd3, 8'd0, 8'd0}, 1'b1};
    vecs[4] = '{32'h2000, 4, NOERR, 1'b0, 1, '{32'h2000, 32'h0, 32'h0},
                '{8'd3, 8'd0, 8'd0}, 1'b0};
    vecs[5] = '{32'h3000, 8, NOERR, 1'b1, 1, '{32'h3000, 32'h0, 32'h0},
                '{8'd7, 8'd0, 8'd0}, 1'b0};
    vecs[6] = '{32'h0FFC, 3, NOERR, 1'b0, 2, '{32'h0FFC, 32'h1000, 32'h0},
                '{8'd0, 8'd1, 8'd0}, 1'b0};

    rst = 1'b1; cmd_addr = '0; cmd_len = '0; cmd_valid = 1'b0;
    tready = 1'b1; arready = 1'b1; r_en = 1'b1; err_addr = NOERR;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_arvalid", {63'd0, arvalid}, 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    check("rst_arlen", 64'(arlen), 64'd0);
    check("rst_rready", {63'd0, rready}, 64'd0);
    check("rst_tvalid", {63'd0, tvalid}, 64'd0);
    check("rst_tlast", {63'd0, tlast}, 64'd0);
    check("rst_status", {62'd0, status_valid, status_error}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // outstanding limit with R data withheld
    r_en = 1'b0;
    err_addr = NOERR;
    base_ar = ar_log.size();
    base_bt = beat_log.size();
    base_rl = rlast_cyc.size();
    max_out = 0;
    send_cmd(32'h4000, 1024);
    repeat (30) @(negedge clk);
    check("lim_ar_count", 64'(ar_log.size() - base_ar), 64'd2);
    check("lim_arvalid_low", {63'd0, arvalid}, 64'd0);
    @(posedge clk);
    #1;
    r_en = 1'b1;
    k = 0;
    @(negedge clk);
    while (ar_log.size() - base_ar < 3 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (ar_log.size() - base_ar >= 3 && rlast_cyc.size() > base_rl)
      check("lim_ar3_after_rlast", {63'd0, ar_cyc[base_ar+2] > rlast_cyc[base_rl]}, 64'd1);
    else
      check("lim_ar3_seen", 64'(ar_log.size() - base_ar), 64'd3);
    wait_status(1'b0, seen, serr, scyc);
    check("lim_status_error", {63'd0, serr}, 64'd0);
    check("lim_nbursts", 64'(ar_log.size() - base_ar), 64'd4);
    check("lim_nbeats", 64'(beat_log.size() - base_bt), 64'd1024);
    check("lim_max_out", 64'(max_out), 64'(MAXO));

    // reset in the middle of ISSUE
    arready = 1'b0;
    send_cmd(32'h0, 600);
    @(negedge clk);
    check("mid_arvalid_pre", {63'd0, arvalid}, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_arvalid", {63'd0, arvalid}, 64'd0);
    check("mid_araddr", 64'(araddr), 64'd0);
    check("mid_busy", {63'd0, busy}, 64'd0);
    check("mid_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("mid_rready", {63'd0, rready}, 64'd0);
    check("mid_status", {62'd0, status_valid, status_error}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    arready = 1'b1;
    run_vec(vecs[0], 10);

    check("ar_stable", 64'(ar_stab_viol), 64'd0);
    check("ar_bubble", 64'(bubble_viol), 64'd0);
    check("ar_outstanding", 64'(out_viol), 64'd0);
    check("rready_mirror", 64'(rready_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
